dest_pop_arbiter: RTL and testbench

//  Sink end of the transaction layer. Drains the two destination FIFOs (D0, D1)

---
 rtl/dest_pop_arbiter_if.sv | 33 +++
 rtl/dest_pop_arbiter.sv | 102 ++++++++++
 tb/tb_dest_pop_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dest_pop_arbiter_if.sv
// Bundle of the two destination-FIFO pop handshakes, the merged sink
// stream, and the delivered-word counters. The arbiter takes the master
// modport and its environment takes the slave modport.
interface dest_pop_arbiter_if #(
    parameter int BITNUMBER = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 D0_can_pop;
    logic                 D1_can_pop;
    logic [BITNUMBER-1:0] data_D0;
    logic [BITNUMBER-1:0] data_D1;
    logic                 sink_pause;
    logic                 pop_D0;
    logic                 pop_D1;
    logic                 valid_out;
    logic [BITNUMBER-1:0] data_out;
    logic                 src_out;
    logic [CNT_WIDTH-1:0] count_D0;
    logic [CNT_WIDTH-1:0] count_D1;
    logic                 idle;

    modport master (
        input  D0_can_pop, D1_can_pop, data_D0, data_D1, sink_pause,
        output pop_D0, pop_D1, valid_out, data_out, src_out,
               count_D0, count_D1, idle
    );

    modport slave (
        output D0_can_pop, D1_can_pop, data_D0, data_D1, sink_pause,
        input  pop_D0, pop_D1, valid_out, data_out, src_out,
               count_D0, count_D1, idle
    );
endinterface

// File: rtl/dest_pop_arbiter.sv
// Sink end of the transaction layer: drains FIFOs D0/D1 through their
// pop/can_pop handshake with round-robin fairness, one pop per cycle, and
// merges the words into a single registered stream tagged with the source.
module dest_pop_arbiter #(
    parameter int BITNUMBER = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dest_pop_arbiter_if.master   bus
);
    // State names which pop strobe is high this cycle.
    typedef enum logic [1:0] {IDLE, SERVE_D0, SERVE_D1} state_t;

    state_t               state_reg, state_next;
    logic                 last_grant_reg, last_grant_next; // 0 = D0, 1 = D1
    logic                 elig0, elig1;
    logic                 flight_valid_reg;   // a pop was issued last cycle
    logic                 flight_src_reg;     // which FIFO that pop went to
    logic                 valid_out_reg;
    logic [BITNUMBER-1:0] data_out_reg;
    logic                 src_out_reg;
    logic [CNT_WIDTH-1:0] count_reg [2];

    // Grant selection: a FIFO popped this cycle is not eligible again until
    // its can_pop has caught up, so back-to-back pops of one FIFO never occur.
    always_comb begin
        state_next      = IDLE;
        last_grant_next = last_grant_reg;
        elig0 = bus.D0_can_pop & ~bus.sink_pause & (state_reg != SERVE_D0);
        elig1 = bus.D1_can_pop & ~bus.sink_pause & (state_reg != SERVE_D1);
        if (elig0 && elig1) begin
            if (last_grant_reg) begin
                state_next      = SERVE_D0;
                last_grant_next = 1'b0;
            end else begin
                state_next      = SERVE_D1;
                last_grant_next = 1'b1;
            end
        end else if (elig0) begin
            state_next      = SERVE_D0;
            last_grant_next = 1'b0;
        end else if (elig1) begin
            state_next      = SERVE_D1;
            last_grant_next = 1'b1;
        end
    end

    // State and round-robin pointer; reset favours D0 on the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Two-stage pipeline: remember the pop, then capture the FIFO read data
    // one cycle later. Reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            flight_valid_reg <= 1'b0;
            flight_src_reg   <= 1'b0;
            valid_out_reg    <= 1'b0;
            data_out_reg     <= '0;
            src_out_reg      <= 1'b0;
        end else begin
            flight_valid_reg <= (state_reg != IDLE);
            flight_src_reg   <= (state_reg == SERVE_D1);
            valid_out_reg    <= flight_valid_reg;
            if (flight_valid_reg) begin
                data_out_reg <= flight_src_reg ? bus.data_D1 : bus.data_D0;
                src_out_reg  <= flight_src_reg;
            end
        end
    end

    // Per-destination delivered-word counters, bumped at the same edge that
    // raises valid_out for that source; they wrap silently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_count
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg[gi] <= '0;
                end else if (flight_valid_reg && (flight_src_reg == 1'(gi))) begin
                    count_reg[gi] <= count_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.pop_D0    = (state_reg == SERVE_D0);
    assign bus.pop_D1    = (state_reg == SERVE_D1);
    assign bus.valid_out = valid_out_reg;
    assign bus.data_out  = data_out_reg;
    assign bus.src_out   = src_out_reg;
    assign bus.count_D0  = count_reg[0];
    assign bus.count_D1  = count_reg[1];
    assign bus.idle      = (state_reg == IDLE) & ~flight_valid_reg & ~valid_out_reg;
endmodule

// File: tb/tb_dest_pop_arbiter.sv
// Directed bench for dest_pop_arbiter: a per-cycle vector table covering
// reset, single-word drain, alternation, pause and single-FIFO pacing, then
// hand-written sequences for reset-while-in-flight and counter wrap.
module tb_dest_pop_arbiter;
    logic clk;
    logic rst;
    logic rst2;
    int   n_vec  = 0;
    int   n_miss = 0;

    dest_pop_arbiter_if #(.BITNUMBER(8), .CNT_WIDTH(8)) bus  ();
    dest_pop_arbiter_if #(.BITNUMBER(8), .CNT_WIDTH(2)) bus2 ();

    dest_pop_arbiter #(.BITNUMBER(8), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    dest_pop_arbiter #(.BITNUMBER(8), .CNT_WIDTH(2)) dut_wrap (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, c0, c1, pause;
        logic [7:0] d0, d1;
        logic       pop0, pop1, valid;
        logic [7:0] data;
        logic       src;
        logic [7:0] cnt0, cnt1;
        logic       idle;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic c0, logic c1, logic p,
                                logic [7:0] d0, logic [7:0] d1,
                                logic pop0, logic pop1, logic v,
                                logic [7:0] data, logic src,
                                logic [7:0] cnt0, logic [7:0] cnt1, logic idl);
        vec_t t;
        t.rst = r; t.c0 = c0; t.c1 = c1; t.pause = p; t.d0 = d0; t.d1 = d1;
        t.pop0 = pop0; t.pop1 = pop1; t.valid = v; t.data = data; t.src = src;
        t.cnt0 = cnt0; t.cnt1 = cnt1; t.idle = idl;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.D0_can_pop  = 0; bus.D1_can_pop  = 0; bus.sink_pause  = 0;
        bus.data_D0     = 0; bus.data_D1     = 0;
        bus2.D0_can_pop = 0; bus2.D1_can_pop = 0; bus2.sink_pause = 0;
        bus2.data_D0    = 0; bus2.data_D1    = 0;

        //   rst c0 c1 p  d0     d1     pop0 pop1 v  data   src cnt0 cnt1 idle
        // reset held, then idle with nothing to pop
        add(1, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(1, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        // single D0 word 0xA5
        add(0, 1, 0, 0, 8'hEE, 8'hDD, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'hA5, 8'hDD, 0, 0, 1, 8'hA5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'hA5, 0, 1, 0, 1);
        // reset, then 4 words in each FIFO: strict alternation D0 first
        add(1, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 1, 1, 0, 8'hEE, 8'hDD, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 0, 8'hEE, 8'hDD, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 0, 8'h10, 8'hDD, 1, 0, 1, 8'h10, 0, 1, 0, 0);
        add(0, 1, 1, 0, 8'hEE, 8'h20, 0, 1, 1, 8'h20, 1, 1, 1, 0);
        add(0, 1, 1, 0, 8'h11, 8'hDD, 1, 0, 1, 8'h11, 0, 2, 1, 0);
        add(0, 1, 1, 0, 8'hEE, 8'h21, 0, 1, 1, 8'h21, 1, 2, 2, 0);
        add(0, 1, 1, 0, 8'h12, 8'hDD, 1, 0, 1, 8'h12, 0, 3, 2, 0);
        add(0, 1, 1, 0, 8'hEE, 8'h22, 0, 1, 1, 8'h22, 1, 3, 3, 0);
        add(0, 0, 1, 0, 8'h13, 8'hDD, 0, 0, 1, 8'h13, 0, 4, 3, 0);
        add(0, 0, 0, 0, 8'hEE, 8'h23, 0, 0, 1, 8'h23, 1, 4, 4, 0);
        add(0, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h23, 1, 4, 4, 1);
        // pause for 5 cycles with two words in flight
        add(0, 1, 1, 0, 8'hEE, 8'hDD, 1, 0, 0, 8'h23, 1, 4, 4, 0);
        add(0, 1, 1, 0, 8'hEE, 8'hDD, 0, 1, 0, 8'h23, 1, 4, 4, 0);
        add(0, 1, 1, 1, 8'h30, 8'hDD, 0, 0, 1, 8'h30, 0, 5, 4, 0);
        add(0, 1, 1, 1, 8'hEE, 8'h40, 0, 0, 1, 8'h40, 1, 5, 5, 0);
        add(0, 1, 1, 1, 8'hEE, 8'hDD, 0, 0, 0, 8'h40, 1, 5, 5, 1);
        add(0, 1, 1, 1, 8'hEE, 8'hDD, 0, 0, 0, 8'h40, 1, 5, 5, 1);
        add(0, 1, 1, 1, 8'hEE, 8'hDD, 0, 0, 0, 8'h40, 1, 5, 5, 1);
        add(0, 1, 1, 0, 8'hEE, 8'hDD, 1, 0, 0, 8'h40, 1, 5, 5, 0);
        add(0, 1, 1, 0, 8'hEE, 8'hDD, 0, 1, 0, 8'h40, 1, 5, 5, 0);
        add(0, 0, 1, 0, 8'h31, 8'hDD, 0, 0, 1, 8'h31, 0, 6, 5, 0);
        add(0, 0, 0, 0, 8'hEE, 8'h41, 0, 0, 1, 8'h41, 1, 6, 6, 0);
        add(0, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h41, 1, 6, 6, 1);
        // only D1, 3 words: pops on alternate cycles
        add(0, 0, 1, 0, 8'hEE, 8'hDD, 0, 1, 0, 8'h41, 1, 6, 6, 0);
        add(0, 0, 1, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h41, 1, 6, 6, 0);
        add(0, 0, 1, 0, 8'hEE, 8'h50, 0, 1, 1, 8'h50, 1, 6, 7, 0);
        add(0, 0, 1, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h50, 1, 6, 7, 0);
        add(0, 0, 1, 0, 8'hEE, 8'h51, 0, 1, 1, 8'h51, 1, 6, 8, 0);
        add(0, 0, 1, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h51, 1, 6, 8, 0);
        add(0, 0, 0, 0, 8'hEE, 8'h52, 0, 0, 1, 8'h52, 1, 6, 9, 0);
        add(0, 0, 0, 0, 8'hEE, 8'hDD, 0, 0, 0, 8'h52, 1, 6, 9, 1);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            bus.D0_can_pop = vecs[i].c0;
            bus.D1_can_pop = vecs[i].c1;
            bus.sink_pause = vecs[i].pause;
            bus.data_D0    = vecs[i].d0;
            bus.data_D1    = vecs[i].d1;
            step();
            chk($sformatf("row%0d {pop0,pop1,valid,data,src,cnt0,cnt1,idle}", i),
                {8'h0, bus.pop_D0, bus.pop_D1, bus.valid_out, bus.data_out,
                 bus.src_out, bus.count_D0, bus.count_D1, bus.idle},
                {8'h0, vecs[i].pop0, vecs[i].pop1, vecs[i].valid, vecs[i].data,
                 vecs[i].src, vecs[i].cnt0, vecs[i].cnt1, vecs[i].idle});
        end

        // Reset in the cycle after the pop: the word in flight is dropped.
        bus.D0_can_pop = 1; bus.data_D0 = 8'hEE;
        step();
        chk("rstflight pop_D0", 32'(bus.pop_D0), 32'd1);
        step();
        chk("rstflight pop_D0 clear", 32'(bus.pop_D0), 32'd0);
        rst = 1; bus.D0_can_pop = 0; bus.data_D0 = 8'h77;
        step();
        chk("rstflight {valid,data,cnt0,cnt1,idle}",
            {7'h0, bus.valid_out, bus.data_out, bus.count_D0, bus.count_D1, bus.idle},
            {7'h0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1});
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rstflight after%0d {valid,cnt0,idle}", k),
                {29'h0, bus.valid_out, bus.count_D0 != 8'h0, bus.idle},
                {29'h0, 1'b0, 1'b0, 1'b1});
        end

        // Counter wrap on the 2-bit instance: 5 D0 words -> count 1.
        rst2 = 0;
        step();
        for (int w = 0; w < 5; w++) begin
            bus2.D0_can_pop = 1;
            step();
            chk($sformatf("wrap w%0d pop", w), 32'(bus2.pop_D0), 32'd1);
            step();
            chk($sformatf("wrap w%0d no repop", w), 32'(bus2.pop_D0), 32'd0);
            bus2.D0_can_pop = 0;
            bus2.data_D0    = 8'h60 + 8'(w);
            step();
            chk($sformatf("wrap w%0d {valid,data,src,cnt0}", w),
                {21'h0, bus2.valid_out, bus2.data_out, bus2.src_out, bus2.count_D0},
                {21'h0, 1'b1, 8'h60 + 8'(w), 1'b0, 2'((w + 1) % 4)});
        end
        step();
        chk("wrap final cnt0", 32'(bus2.count_D0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
